seq_detect_param: RTL and testbench

//  Parametrised serial bit-pattern detector, successor to the fixed 3-bit "101" detector.

---
 rtl/seq_detect_param.sv | 119 +++++++++++
 tb/tb_seq_detect_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Serial bit-pattern detector with a runtime-programmable PAT_LEN-bit pattern,
//   a per-bit don't-care mask and selectable overlapping/non-overlapping matching
//   on a valid-qualified serial stream.
//
// Parameters
//   PAT_LEN      pattern length in bits (2..32)
//   CNT_W        match counter width
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   d            serial data bit
//   d_valid      d is sampled only when 1
//   cfg_load     1-cycle pulse: latch cfg_pattern / cfg_care / cfg_overlap
//   cfg_pattern  pattern, bit PAT_LEN-1 is the earliest received bit
//   cfg_care     1 = compare bit, 0 = don't-care (same bit order)
//   cfg_overlap  1 = overlapping matches allowed
//   match        registered 1-cycle pulse per detected pattern
//   match_count  saturating match count (tied to 0 without MATCH_COUNT_EN)
//   cnt_clr      synchronous clear of match_count
//
// Build option
//   MATCH_COUNT_EN  when defined, enables the saturating match counter.
module seq_detect_param #(
  parameter int unsigned PAT_LEN = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               d,
  input  logic               d_valid,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic [PAT_LEN-1:0] cfg_care,
  input  logic               cfg_overlap,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  input  logic               cnt_clr
);

  localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);

  logic [PAT_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [PAT_LEN-1:0] r_pattern;
  logic [PAT_LEN-1:0] r_care;
  logic               r_overlap;
  logic               r_match;

  logic               w_accept;
  logic [PAT_LEN-1:0] w_hist_n;
  logic [FILL_W-1:0]  w_fill_inc;
  logic [FILL_W-1:0]  w_fill_n;
  logic               w_full_n;
  logic               w_hit;

  // A configuration load discards any bit offered in the same cycle.
  assign w_accept   = d_valid & ~cfg_load;
  assign w_hist_n   = {r_hist[PAT_LEN-2:0], d};
  assign w_fill_inc = (r_fill == FILL_W'(PAT_LEN)) ? r_fill : r_fill + FILL_W'(1);
  assign w_full_n   = (w_fill_inc == FILL_W'(PAT_LEN));

  // Fill gating keeps stale history (reset zeros, pre-load bits) from matching.
  assign w_hit = w_accept & w_full_n &
                 (((w_hist_n ^ r_pattern) & r_care) == '0);

  // Non-overlapping mode restarts the fill so the next match needs PAT_LEN new bits.
  assign w_fill_n = (w_hit & ~r_overlap) ? '0 : w_fill_inc;

  // Shift history, fill counter, configuration and match pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= '0;
      r_care    <= '1;
      r_overlap <= 1'b1;
      r_match   <= 1'b0;
    end else if (cfg_load) begin
      r_pattern <= cfg_pattern;
      r_care    <= cfg_care;
      r_overlap <= cfg_overlap;
      r_fill    <= '0;
      r_match   <= 1'b0;
    end else if (w_accept) begin
      r_hist    <= w_hist_n;
      r_fill    <= w_fill_n;
      r_match   <= w_hit;
    end else begin
      r_match   <= 1'b0;
    end
  end

  assign match = r_match;

`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0] r_count;

  // Saturating match counter; clear takes priority over a same-cycle hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (cnt_clr) begin
      r_count <= '0;
    end else if (w_hit && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign match_count = r_count;
`else
  logic w_unused_cnt_clr;

  assign w_unused_cnt_clr = cnt_clr;
  assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param (PAT_LEN=3, CNT_W=2).
module tb_seq_detect_param;

  localparam int unsigned PL = 3;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          d;
  logic          d_valid;
  logic          cfg_load;
  logic [PL-1:0] cfg_pattern;
  logic [PL-1:0] cfg_care;
  logic          cfg_overlap;
  logic          match;
  logic [CW-1:0] match_count;
  logic          cnt_clr;

  seq_detect_param #(.PAT_LEN(PL), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .d           (d),
    .d_valid     (d_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_care    (cfg_care),
    .cfg_overlap (cfg_overlap),
    .match       (match),
    .match_count (match_count),
    .cnt_clr     (cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          d;
    logic          vld;
    logic          ld;
    logic          ovl;
    logic [PL-1:0] pat;
    logic [PL-1:0] care;
    logic          exp_m;
  } vec_t;

  typedef struct {
    logic          m;
    logic          chk_cnt;
    logic [CW-1:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [CW-1:0] cnt_e(input logic [CW-1:0] v);
`ifdef MATCH_COUNT_EN
    return v;
`else
    return CW'(0);
`endif
  endfunction

  function automatic void add(input logic vd, input logic vv, input logic vl,
                              input logic vo, input logic [PL-1:0] vp,
                              input logic [PL-1:0] vc, input logic em);
    vec_t v;
    v.d = vd; v.vld = vv; v.ld = vl; v.ovl = vo; v.pat = vp; v.care = vc; v.exp_m = em;
    vecs.push_back(v);
  endfunction

  task automatic check(input string tag);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      if (match !== e.m) begin
        bad++;
        $display("FAIL %s: match got %b want %b", tag, match, e.m);
      end
      if (e.chk_cnt) begin
        total++;
        if (match_count !== e.cnt) begin
          bad++;
          $display("FAIL %s: match_count got %0d want %0d", tag, match_count, e.cnt);
        end
      end
    end
  endtask

  task automatic step(input logic vd, input logic vv, input logic vl, input logic vclr,
                      input logic vo, input logic [PL-1:0] vp, input logic [PL-1:0] vc,
                      input logic em, input logic cc, input logic [CW-1:0] ec,
                      input string tag);
    exp_t e;
    @(negedge clk);
    d = vd; d_valid = vv; cfg_load = vl; cnt_clr = vclr;
    cfg_overlap = vo; cfg_pattern = vp; cfg_care = vc;
    e.m = em; e.chk_cnt = cc; e.cnt = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic chk_now(input string tag, input logic em, input logic [CW-1:0] ec);
    total++;
    if (match !== em || match_count !== ec) begin
      bad++;
      $display("FAIL %s: match/count got %b/%0d want %b/%0d", tag, match, match_count, em, ec);
    end
  endtask

  initial begin
    // After reset: pattern 000, care 111, overlap; d_valid gaps are transparent.
    add(0,1,0,1,3'b000,3'b111,0); add(1,0,0,1,3'b000,3'b111,0);
    add(0,1,0,1,3'b000,3'b111,0); add(1,0,0,1,3'b000,3'b111,0);
    add(0,1,0,1,3'b000,3'b111,1); add(0,1,0,1,3'b000,3'b111,1);
    // 101 overlapping.
    add(0,0,1,1,3'b101,3'b111,0);
    add(1,1,0,0,3'b000,3'b000,0); add(0,1,0,0,3'b000,3'b000,0);
    add(1,1,0,0,3'b000,3'b000,1); add(0,1,0,0,3'b000,3'b000,0);
    add(1,1,0,0,3'b000,3'b000,1); add(1,0,0,0,3'b000,3'b000,0);
    // 101 non-overlapping: fill restarts after each match.
    add(0,0,1,0,3'b101,3'b111,0);
    add(1,1,0,0,3'b000,3'b000,0); add(0,1,0,0,3'b000,3'b000,0);
    add(1,1,0,0,3'b000,3'b000,1); add(0,1,0,0,3'b000,3'b000,0);
    add(1,1,0,0,3'b000,3'b000,0);
    add(1,1,0,0,3'b000,3'b000,0); add(0,1,0,0,3'b000,3'b000,0);
    add(1,1,0,0,3'b000,3'b000,1); add(0,1,0,0,3'b000,3'b000,0);
    add(1,1,0,0,3'b000,3'b000,0);
    // 1x1 overlapping.
    add(0,0,1,1,3'b101,3'b101,0);
    add(1,1,0,0,3'b000,3'b000,0); add(1,1,0,0,3'b000,3'b000,0);
    add(1,1,0,0,3'b000,3'b000,1); add(0,1,0,0,3'b000,3'b000,0);
    add(0,1,0,0,3'b000,3'b000,0); add(1,1,0,0,3'b000,3'b000,0);
    add(1,1,0,0,3'b000,3'b000,0); add(0,1,0,0,3'b000,3'b000,0);
    add(1,1,0,0,3'b000,3'b000,1); add(1,1,0,0,3'b000,3'b000,0);
    add(1,1,0,0,3'b000,3'b000,1);
    // Mid-stream reload with a same-cycle valid bit: that bit is dropped.
    add(0,0,1,1,3'b101,3'b111,0);
    add(1,1,0,0,3'b000,3'b000,0); add(0,1,0,0,3'b000,3'b000,0);
    add(1,1,1,1,3'b011,3'b111,0);
    add(1,1,0,0,3'b000,3'b000,0); add(1,1,0,0,3'b000,3'b000,0);
    add(0,1,0,0,3'b000,3'b000,0); add(1,1,0,0,3'b000,3'b000,0);
    add(1,1,0,0,3'b000,3'b000,1);
    // All don't-care, non-overlapping: every third accepted bit hits.
    add(0,0,1,0,3'b000,3'b000,0);
    add(1,1,0,0,3'b000,3'b000,0); add(0,1,0,0,3'b000,3'b000,0);
    add(1,1,0,0,3'b000,3'b000,1); add(1,1,0,0,3'b000,3'b000,0);
    add(1,1,0,0,3'b000,3'b000,0); add(0,1,0,0,3'b000,3'b000,1);
    add(0,0,0,0,3'b000,3'b000,0);

    reset = 1'b1; d = 1'b0; d_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    cfg_overlap = 1'b0; cfg_pattern = '0; cfg_care = '0;
    #12;
    chk_now("reset", 1'b0, CW'(0));
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].d, vecs[i].vld, vecs[i].ld, 1'b0, vecs[i].ovl, vecs[i].pat,
           vecs[i].care, vecs[i].exp_m, 1'b0, CW'(0), $sformatf("vec%0d", i));
    end

    // Counter: 111 overlapping, six 1s, saturation at 3, clear priority.
    step(0,0,1,1,1,3'b111,3'b111,0,1,cnt_e(0),"cnt_load");
    step(1,1,0,0,0,3'b000,3'b000,0,1,cnt_e(0),"cnt_b1");
    step(1,1,0,0,0,3'b000,3'b000,0,1,cnt_e(0),"cnt_b2");
    step(1,1,0,0,0,3'b000,3'b000,1,1,cnt_e(1),"cnt_b3");
    step(1,1,0,0,0,3'b000,3'b000,1,1,cnt_e(2),"cnt_b4");
    step(1,1,0,0,0,3'b000,3'b000,1,1,cnt_e(3),"cnt_b5");
    step(1,1,0,0,0,3'b000,3'b000,1,1,cnt_e(3),"cnt_sat");
    step(1,1,0,1,0,3'b000,3'b000,1,1,cnt_e(0),"cnt_clr_hit");
    step(1,0,0,0,0,3'b000,3'b000,0,1,cnt_e(0),"cnt_gap");
    step(1,1,0,0,0,3'b000,3'b000,1,1,cnt_e(1),"cnt_again");
    step(0,0,1,0,1,3'b111,3'b111,0,1,cnt_e(1),"cnt_keep_on_load");
    step(1,1,0,0,0,3'b000,3'b000,0,1,cnt_e(1),"rs_b1");
    step(1,1,0,0,0,3'b000,3'b000,0,1,cnt_e(1),"rs_b2");
    step(1,1,0,0,0,3'b000,3'b000,1,1,cnt_e(2),"rs_b3");

    // Asynchronous reset between edges clears the outputs immediately.
    #2;
    reset = 1'b1;
    #1;
    chk_now("async_reset", 1'b0, CW'(0));
    @(negedge clk);
    reset = 1'b0;
    step(0,1,0,0,0,3'b000,3'b000,0,1,cnt_e(0),"post_rst_b1");
    step(0,1,0,0,0,3'b000,3'b000,0,1,cnt_e(0),"post_rst_b2");
    step(0,1,0,0,0,3'b000,3'b000,1,1,cnt_e(1),"post_rst_b3");

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
